// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, FSM state encoding and helpers for alu_rr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_NEG  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      INV  = 2'b01,
      EXEC = 2'b10,
      RESP = 2'b11
   } state_t;

   // Two's-complement ops get an invert pass before the carry-in add.
   function automatic logic needs_inv(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_NEG);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_arb2.sv
// ============================================================================
// Module      : alu_rr_arb2
// Description : Combinational 2-way round-robin grant; owner of last_grant is
//               the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt0,
   output logic gnt1
);

   // On a tie the requester that did not win last time is served.
   always_comb begin
      gnt0 = valid0 & (~valid1 | last_grant);
      gnt1 = valid1 & (~valid0 | ~last_grant);
   end

endmodule

`default_nettype wire

// File: rtl/alu_rr_sequencer.sv
// ============================================================================
// Module      : alu_rr_sequencer
// Description : Two-requester round-robin front end sharing one multi-step ALU.
//               Optional done counters enabled by macro ALU_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_sequencer #(
   parameter int WIDTH = 6,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
`ifdef ALU_SEQ_STATS_EN
   output logic             busy,
   output logic [7:0]       done_cnt0,
   output logic [7:0]       done_cnt1
`else
   output logic             busy
`endif
);

   import alu_seq_pkg::*;

   state_t           r_state;
   state_t           w_next;
   logic             r_last_grant;
   logic [OPW-1:0]   r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic             r_cin;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_carry;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic [OPW-1:0]   w_sel_op;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;

   alu_rr_arb2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (r_last_grant),
      .gnt0       (w_gnt0),
      .gnt1       (w_gnt1)
   );

   // Readies are masked while reset is asserted so nothing looks accepted.
   always_comb begin
      req0_ready = rst_n && (r_state == IDLE) && w_gnt0;
      req1_ready = rst_n && (r_state == IDLE) && w_gnt1;
      w_accept   = req0_ready || req1_ready;
      w_sel_op   = w_gnt1 ? req1_op : req0_op;
      w_sel_a    = w_gnt1 ? req1_a  : req0_a;
      w_sel_b    = w_gnt1 ? req1_b  : req0_b;
      rsp_valid  = (r_state == RESP);
      busy       = (r_state != IDLE);
      rsp_id     = r_id;
      rsp_data   = r_rsp_data;
      rsp_carry  = r_rsp_carry;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = needs_inv(w_sel_op) ? INV : EXEC;
         INV:  w_next = EXEC;
         EXEC: w_next = RESP;
         RESP: if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NEG already holds ~A in r_a, so it only needs the carry-in added.
   always_comb begin
      w_addend = (r_op == OP_NEG) ? '0 : r_b;
      w_sum    = {1'b0, r_a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, r_cin};
      w_res    = '0;
      w_carry  = 1'b0;
      case (r_op)
         OP_PASS: w_res = r_a;
         OP_NOT:  w_res = ~r_a;
         OP_ADD, OP_SUB, OP_NEG: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
         end
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_XOR:  w_res = r_a ^ r_b;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= 1'b0;
         r_cin        <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_carry  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_op         <= w_sel_op;
               r_a          <= w_sel_a;
               r_b          <= w_sel_b;
               r_id         <= w_gnt1;
               r_last_grant <= w_gnt1;
               r_cin        <= 1'b0;
            end
            INV: begin
               if (r_op == OP_SUB) r_b <= ~r_b;
               else                r_a <= ~r_a;
               r_cin <= 1'b1;
            end
            EXEC: begin
               r_rsp_data  <= w_res;
               r_rsp_carry <= w_carry;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   logic [7:0] r_done_cnt0;
   logic [7:0] r_done_cnt1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_done_cnt0 <= 8'd0;
         r_done_cnt1 <= 8'd0;
      end else if (rsp_valid && rsp_ready) begin
         if (!r_id && r_done_cnt0 != 8'hFF) r_done_cnt0 <= r_done_cnt0 + 8'd1;
         if ( r_id && r_done_cnt1 != 8'hFF) r_done_cnt1 <= r_done_cnt1 + 8'd1;
      end
   end

   assign done_cnt0 = r_done_cnt0;
   assign done_cnt1 = r_done_cnt1;
`endif

endmodule

`default_nettype wire
